serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/result width in bits (legal W >= 2).
REQ-002 SHALL have one clock and an asynchronous active-low reset, ports as below.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_valid  input  1  requester offers operands.
REQ-006 SHALL have port start_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  minuend, sampled only at acceptance.
REQ-008 SHALL have port b  input  W  subtrahend, sampled only at acceptance.
REQ-009 SHALL have port res_valid  output  1  diff/borout hold a completed result.
REQ-010 SHALL have port res_ready  input  1  consumer takes the result.
REQ-011 SHALL have port diff  output  W  result a-b, modulo 2^W.
REQ-012 SHALL have port borout  output  1  final borrow; 1 means a < b unsigned.
REQ-013 SHALL have port busy  output  1  high in SHIFT state.

Function
REQ-014 SHALL use FSM states IDLE, SHIFT, DONE; start_ready = (state==IDLE); res_valid = (state==DONE).
REQ-015 Acceptance SHALL occur on an edge with start_valid & start_ready: latch a, b into shift registers, clear borrow and bit counter, go to SHIFT.
REQ-016 In SHIFT, SHALL process one bit per cycle, LSB first: d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin); bout is registered as next bin.
REQ-017 In SHIFT, SHALL shift a and b right by one and shift d into the MSB of the diff register.
REQ-018 The bit counter SHALL count 0..W-1; on the edge processing bit W-1 the FSM SHALL enter DONE.
REQ-019 Latency: acceptance on edge T SHALL give res_valid=1 from edge T+W, with diff and borout final at that time.
REQ-020 In DONE, diff and borout SHALL hold stable until res_valid & res_ready; that edge returns the FSM to IDLE.
REQ-021 start_valid outside IDLE SHALL be ignored with no side effect; a and b changes outside acceptance SHALL have no effect.
REQ-022 res_ready outside DONE SHALL be ignored.
REQ-023 Back-to-back: after the result-handoff edge, the next acceptance is possible on the following edge; the minimum period is W+2 cycles.
REQ-024 diff and borout SHALL keep the last result in IDLE until the next acceptance clears them.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, counter=0, borrow=0, diff=0, borout=0, res_valid=0, busy=0; start_ready SHALL be 1.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation and discard the result; no res_valid pulse follows.

Configuration
REQ-027 Macro SERIAL_SUB_SAT_EN defined: in DONE, when borout=1, diff SHALL read 0 (saturating unsigned subtract); borout still reports 1.
REQ-028 Macro SERIAL_SUB_SAT_EN undefined: diff SHALL be the raw two's-complement result in all cases.

Structure
REQ-029 Package serial_sub_pkg SHALL hold the state typedef (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default width constant 32.
REQ-030 The 1-bit borrow cell SHALL be sub-module sub_bit_cell (combinational; ports bout, d, a, b, bin) instantiated once.

Verification
REQ-031 Accept a=10, b=3 at edge T -> res_valid at T+32, diff=7, borout=0, start_ready=0 during T..T+32.
REQ-032 a=3, b=10 -> diff=0xFFFFFFF9, borout=1; with SERIAL_SUB_SAT_EN: diff=0, borout=1.
REQ-033 a=0x80000000, b=1 -> diff=0x7FFFFFFF, borout=0; a=0, b=0 -> diff=0, borout=0.
REQ-034 Hold res_ready=0 for 5 cycles in DONE while start_valid=1 with new operands -> diff/borout stable, no second acceptance; res_ready=1 -> IDLE next edge, new acceptance the edge after.
REQ-035 Assert rst_n=0 at SHIFT cycle 10 -> all outputs 0 immediately, start_ready=1; no res_valid until a fresh acceptance plus W cycles.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and width default for the serial subtractor
package serial_sub_pkg;

   localparam int SUB_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// rtl/sub_bit_cell.sv - one-bit full subtractor cell (difference and borrow-out)
module sub_bit_cell (
   output logic bout,
   output logic d,
   input  logic a,
   input  logic b,
   input  logic bin
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial W-bit subtractor with valid/ready handshakes
// Optional SERIAL_SUB_SAT_EN: diff reads 0 in DONE when the result borrowed.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int W = SUB_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] diff,
   output logic         borout,
   output logic         busy
);

   localparam int CW = $clog2(W);

   state_t        state;
   state_t        state_nx;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  diff_r;
   logic [CW-1:0] cnt;
   logic          bin;
   logic          d_bit;
   logic          bout_bit;
   logic          accept;
   logic          last_bit;

   assign accept   = start_valid && (state == IDLE);
   assign last_bit = (cnt == CW'(W - 1));

   sub_bit_cell u_cell (
      .bout (bout_bit),
      .d    (d_bit),
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (bin)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_valid) state_nx = SHIFT;
         SHIFT:   if (last_bit)    state_nx = DONE;
         DONE:    if (res_ready)   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Difference bits enter at the MSB so bit 0 lands in place after W shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         diff_r <= '0;
         bin    <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         diff_r <= '0;
         bin    <= 1'b0;
         cnt    <= '0;
      end else if (state == SHIFT) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         diff_r <= {d_bit, diff_r[W-1:1]};
         bin    <= bout_bit;
         cnt    <= cnt + CW'(1);
      end
   end

   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);
   assign busy        = (state == SHIFT);
   assign borout      = bin;

`ifdef SERIAL_SUB_SAT_EN
   assign diff = (res_valid && bin) ? '0 : diff_r;
`else
   assign diff = diff_r;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] diff;
      logic         borout;
      logic [W-1:0] raw;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] diff;
   logic         borout;
   logic         busy;

   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t sb[$];

   serial_sub_ctrl #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .diff        (diff),
      .borout      (borout),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t       e;
      logic [W:0] r;
      r        = {1'b0, x} - {1'b0, y};
      e.raw    = r[W-1:0];
      e.borout = r[W];
      e.diff   = r[W-1:0];
`ifdef SERIAL_SUB_SAT_EN
      if (r[W]) e.diff = '0;
`endif
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after the accepting posedge.
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
      int guard;
      start_valid = 1'b1;
      a = x;
      b = y;
      guard = 0;
      while (!start_ready && guard < 4 * W) begin
         @(negedge clk);
         guard++;
      end
      chk("accept_wait", 64'(start_ready), 64'd1);
      sb.push_back(model(x, y));
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   // Returns at the negedge where res_valid is first seen.
   task automatic wait_result();
      int   cyc;
      logic sr_bad;
      logic bz_bad;
      cyc = 0;
      sr_bad = 1'b0;
      bz_bad = 1'b0;
      while (cyc < W + 8) begin
         @(negedge clk);
         if (res_valid) break;
         sr_bad |= start_ready;
         bz_bad |= ~busy;
         @(posedge clk);
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(W));
      chk("start_ready_low_in_shift", 64'(sr_bad), 64'd0);
      chk("busy_high_in_shift", 64'(bz_bad), 64'd0);
   endtask

   // Holds res_ready low for 'hold' cycles while offering junk operands, then hands off.
   task automatic take_result(input int hold);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_nonempty", 64'd0, 64'd1);
         return;
      end
      e = sb[0];
      for (int i = 0; i < hold; i++) begin
         start_valid = 1'b1;
         a = $urandom;
         b = $urandom;
         @(posedge clk);
         @(negedge clk);
         chk("hold_diff", 64'(diff), 64'(e.diff));
         chk("hold_borout", 64'(borout), 64'(e.borout));
         chk("hold_valid", 64'(res_valid), 64'd1);
         chk("hold_no_accept", 64'(start_ready), 64'd0);
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      e = sb.pop_front();
      chk("res_valid", 64'(res_valid), 64'd1);
      chk("diff", 64'(diff), 64'(e.diff));
      chk("borout", 64'(borout), 64'(e.borout));
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk("idle_start_ready", 64'(start_ready), 64'd1);
      chk("idle_res_valid", 64'(res_valid), 64'd0);
      chk("idle_borout_kept", 64'(borout), 64'(e.borout));
      chk("idle_diff_kept", 64'(diff), 64'(e.raw));
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
      start_op(x, y);
      wait_result();
      take_result(0);
   endtask

   initial begin
      int vcnt;
      #2;
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_diff", 64'(diff), 64'd0);
      chk("rst_borout", 64'(borout), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'd10, 32'd3);
      run_op(32'd3, 32'd10);
      run_op(32'h8000_0000, 32'd1);
      run_op(32'd0, 32'd0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(32'd0, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) run_op($urandom, $urandom);

      // Stall in DONE with new operands offered, then back-to-back acceptance.
      start_op(32'h1234_5678, 32'h0000_5679);
      wait_result();
      take_result(5);
      start_op(32'h0000_0005, 32'h0000_0007);
      wait_result();
      take_result(2);

      // Reset in the middle of SHIFT aborts the operation.
      start_op(32'hDEAD_BEEF, 32'h0000_0001);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_start_ready", 64'(start_ready), 64'd1);
      chk("abort_res_valid", 64'(res_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_diff", 64'(diff), 64'd0);
      chk("abort_borout", 64'(borout), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < W + 6; i++) begin
         @(negedge clk);
         if (res_valid) vcnt++;
      end
      chk("abort_no_valid", 64'(vcnt), 64'd0);
      run_op(32'd100, 32'd58);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
